kernel: RTL and testbench
=========================

# kernel

Streaming 3x3 convolution kernel for the CNN datapath. It consumes one 8-bit pixel per clock from an 8x8 frame in raster order and loads its nine 8-bit weights from the first nine cycles of each frame. It produces one scaled, saturated 8-bit result per fully-populated 3x3 window, giving 36 results per frame. It sits between the pixel source and the downstream pooling/activation stage.

## Interface
- IMG_W, 8: frame width in pixels (line-buffer depth).
- IMG_H, 8: frame height in rows; frame length is IMG_W*IMG_H = 64 cycles.
- SHIFT, 8: right shift applied to the accumulated sum before saturation.
- clock  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- inpixel  input  8  unsigned pixel, sampled every clock while out of reset.
- weight_in  input  8  unsigned weight, sampled on frame cycles 0..8 only.
- dout  output  8  unsigned convolution result, registered.

## Operation
- No handshake: every rising edge out of reset accepts one pixel.
- Pixels arrive in raster order. Counters col (0..7) and row (0..7) advance per pixel. col wraps to 0 and increments row. row wraps 7->0 at frame end (pixel 63), and the next pixel starts a new frame.
- Weight load: on frame cycles k = 0..8, weight_in is stored as w[k]. w[k] is used for window position row k/3, col k%3, where (0,0) is the top-left (oldest) pixel.
- Weights hold until cycles 0..8 of the next frame overwrite them.
- The first frame after reset uses the weights loaded in its own cycles 0..8. These are always complete before the first valid window at pixel 18.
- Line buffers: two IMG_W-deep shift registers hold the previous two rows. A 3x3 window register shifts in one column per pixel: rows r-2, r-1, r.
- Window valid when the current pixel has row >= 2 and col >= 2. Windows with col < 2 straddle rows; they are discarded and dout is not updated.
- Arithmetic:
  - Nine unsigned 8x8 products, each 16 bits.
  - Summed in a 20-bit accumulator (max 585225, no overflow).
  - result = sum >> SHIFT, then saturated to 255.
- dout holds its last value between valid windows, including across frame boundaries.

## Timing
- Reset (async assert, any time): dout = 0, counters = 0, line buffers, window and weights = 0. Pipeline valid flags cleared.
- The first pixel sampled after deassertion is frame pixel 0.
- Pipeline has two register stages: stage 1 registers the products, stage 2 registers the saturated sum into dout.
- dout reflects the window completed by pixel n at the clock edge after the one that samples pixel n+1. Latency is 2 cycles from sample edge to dout update.
- Valid windows complete at pixels 18..23, 26..31, ..., 58..63, giving 36 updates per frame. The last update of a frame lands 2 cycles after pixel 63, overlapping the next frame's weight load without interference.
- Reset mid-frame aborts the frame: in-flight results are dropped and weights must be reloaded.

## Test plan
- Ramp: inpixel = i, weight_in = i+1 for i = 0..63 -> first window (pixel 18) sum 555, dout = 2 two cycles later. Pixel 19 sum 600 -> 2.
- Weights set to 0 on cycles 0..8, pixels arbitrary -> dout stays 0 for all 36 windows.
- Saturation: all weights 255, all pixels 255 -> sum 585225, >>8 = 2286 -> dout = 255.
- Identity: w[4] = 255<<0, i.e. w = {0,0,0,0,255,0,0,0,0}, ramp pixels -> dout = (center*255)>>8. For the pixel-18 window (center 9) dout = 8.
- Edge discard: ramp stimulus -> dout unchanged during pixels 24..25 (col 0..1), and exactly 36 updates per frame.
- Reset mid-frame at pixel 30 -> dout = 0 immediately. Next frame restarts at pixel 0 with fresh weights, and the first update again follows pixel 18.

Source files
------------

// File: rtl/kernel.sv
// Streaming 3x3 convolution over an IMG_W x IMG_H raster frame.
// Nine weights are captured from the first nine pixels of each frame. Every
// fully populated window produces one scaled, saturated 8-bit result.
// Two pipeline stages sit between the sample edge and dout:
// the products, then the saturated sum.
module kernel #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int SHIFT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] inpixel,
    input  logic [7:0] weight_in,
    output logic [7:0] dout
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int IDX_W = $clog2(IMG_W * IMG_H);
    localparam int SUM_W = 20;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [IDX_W-1:0] w_idx;
    logic             w_win_ok;

    logic [7:0]       r_w    [9];
    logic [7:0]       r_lb1  [IMG_W];
    logic [7:0]       r_lb2  [IMG_W];
    // Window index = 3*row + col; row 0 is the oldest line, col 0 the oldest column.
    logic [7:0]       r_win  [9];
    logic             r_win_vld;

    logic [15:0]      r_prod [9];
    logic             r_prod_vld;

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_shifted;
    logic [7:0]       w_sat;

    // Position of the pixel being sampled this cycle within the frame.
    assign w_idx    = IDX_W'(r_row) * IDX_W'(IMG_W) + IDX_W'(r_col);
    // Windows whose left columns come from the previous row are discarded.
    assign w_win_ok = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // Raster counters: col wraps into row, row wraps at the end of the frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_col == COL_W'(IMG_W - 1)) begin
            r_col <= '0;
            if (r_row == ROW_W'(IMG_H - 1)) begin
                r_row <= '0;
            end else begin
                r_row <= r_row + ROW_W'(1);
            end
        end else begin
            r_col <= r_col + COL_W'(1);
        end
    end

    // Weight capture on frame cycles 0..8; the weights hold for the rest of the frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 9; k++) r_w[k] <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (w_idx == IDX_W'(k)) r_w[k] <= weight_in;
            end
        end
    end

    // Line buffers delay by one and two rows; the window shifts in one column per pixel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb1[i] <= '0;
                r_lb2[i] <= '0;
            end
            for (int k = 0; k < 9; k++) r_win[k] <= '0;
            r_win_vld <= 1'b0;
        end else begin
            r_lb1[0] <= inpixel;
            r_lb2[0] <= r_lb1[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
            for (int i = 0; i < 3; i++) begin
                r_win[3*i]   <= r_win[3*i+1];
                r_win[3*i+1] <= r_win[3*i+2];
            end
            r_win[2]  <= r_lb2[IMG_W-1];
            r_win[5]  <= r_lb1[IMG_W-1];
            r_win[8]  <= inpixel;
            r_win_vld <= w_win_ok;
        end
    end

    // Stage 1: register the nine products of the window that just completed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 9; k++) r_prod[k] <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) r_prod[k] <= 16'(r_win[k]) * 16'(r_w[k]);
            r_prod_vld <= r_win_vld;
        end
    end

    // Adder tree, scale and saturate; 20 bits holds 9*255*255 without overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) w_sum = w_sum + SUM_W'(r_prod[k]);
        w_shifted = w_sum >> SHIFT;
        w_sat     = (w_shifted > SUM_W'(255)) ? 8'hFF : w_shifted[7:0];
    end

    // Stage 2: dout updates only for valid windows and otherwise holds.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (r_prod_vld) begin
            dout <= w_sat;
        end
    end

endmodule

// File: tb/tb_kernel.sv
// Directed bench for the streaming 3x3 convolution kernel.
// Inputs are driven on the falling edge and dout is sampled there too.
// obs[g] is dout after edge g-1, which is the value present while pixel g is driven.
module tb_kernel;

    localparam int NMAX = 200;

    logic       clock;
    logic       reset;
    logic [7:0] inpixel;
    logic [7:0] weight_in;
    logic [7:0] dout;

    logic [7:0] s_pix [0:NMAX-1];
    logic [7:0] s_w   [0:NMAX-1];
    logic [7:0] obs   [0:NMAX-1];
    logic [7:0] expv  [0:NMAX-1];

    int checks;
    int failures;

    kernel #(.IMG_W(8), .IMG_H(8), .SHIFT(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .inpixel   (inpixel),
        .weight_in (weight_in),
        .dout      (dout)
    );

    // Clock: 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic clear_stim();
        for (int i = 0; i < NMAX; i++) begin
            s_pix[i] = 8'd0;
            s_w[i]   = 8'd0;
        end
    endtask

    // Called at a falling edge; releases reset at a later falling edge.
    task automatic apply_reset();
        reset     = 1'b0;
        inpixel   = 8'd0;
        weight_in = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Drives n pixels starting at the current falling edge. It records dout
    // and builds the expected value from a window model that indexes the
    // frame directly.
    task automatic run_stream(input int n);
        int wm [9];
        int expc, p1, p2, res, sum, k, r, c, base;
        bit p1v, p2v, cv;
        expc = 0; p1 = 0; p2 = 0; p1v = 0; p2v = 0;
        for (int i = 0; i < 9; i++) wm[i] = 0;
        for (int g = 0; g < n; g++) begin
            obs[g]    = dout;
            expv[g]   = 8'(expc);
            inpixel   = s_pix[g];
            weight_in = s_w[g];
            base = (g / 64) * 64;
            k    = g % 64;
            r    = k / 8;
            c    = k % 8;
            if (k < 9) wm[k] = int'(s_w[g]);
            if (p2v) expc = p2;
            p2v = p1v;
            p2  = p1;
            cv  = (r >= 2) && (c >= 2);
            res = 0;
            if (cv) begin
                sum = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        sum += int'(s_pix[base + (r - 2 + i) * 8 + (c - 2 + j)]) * wm[3*i + j];
                res = sum >> 8;
                if (res > 255) res = 255;
            end
            p1v = cv;
            p1  = res;
            @(negedge clock);
        end
        obs[n]  = dout;
        expv[n] = 8'(expc);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        inpixel   = 8'hA5;
        weight_in = 8'h5A;
        repeat (3) @(negedge clock);
        checks++;
        if (dout !== 8'd0) begin
            failures++;
            $display("FAIL reset_dout got %0d exp 0", dout);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ramp();
        apply_reset();
        clear_stim();
        for (int i = 0; i < 64; i++) begin
            s_pix[i] = 8'(i);
            s_w[i]   = 8'(i + 1);
        end
        run_stream(66);
        checks++;
        if (obs[20] !== 8'd0) begin failures++; $display("FAIL ramp_before_first got %0d exp 0", obs[20]); end
        checks++;
        if (obs[21] !== 8'd2) begin failures++; $display("FAIL ramp_px18 got %0d exp 2", obs[21]); end
        checks++;
        if (obs[22] !== 8'd2) begin failures++; $display("FAIL ramp_px19 got %0d exp 2", obs[22]); end
        checks++;
        if (obs[66] !== 8'd10) begin failures++; $display("FAIL ramp_px63 got %0d exp 10", obs[66]); end
        for (int g = 0; g <= 66; g++) begin
            checks++;
            if (obs[g] !== expv[g]) begin
                failures++;
                $display("FAIL ramp_stream cycle %0d got %0d exp %0d", g, obs[g], expv[g]);
            end
        end
    endtask

    task automatic test_zero_weights();
        apply_reset();
        clear_stim();
        for (int i = 0; i < 66; i++) begin
            s_pix[i] = 8'((i * 53 + 7) & 255);
            s_w[i]   = (i < 9) ? 8'd0 : 8'hFF;
        end
        run_stream(66);
        for (int g = 0; g <= 66; g++) begin
            checks++;
            if (obs[g] !== 8'd0) begin
                failures++;
                $display("FAIL zero_weights cycle %0d got %0d exp 0", g, obs[g]);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        clear_stim();
        for (int i = 0; i < 66; i++) begin
            s_pix[i] = 8'hFF;
            s_w[i]   = 8'hFF;
        end
        run_stream(66);
        checks++;
        if (obs[20] !== 8'd0) begin failures++; $display("FAIL sat_before_first got %0d exp 0", obs[20]); end
        for (int g = 21; g <= 66; g++) begin
            checks++;
            if (obs[g] !== 8'd255) begin
                failures++;
                $display("FAIL saturation cycle %0d got %0d exp 255", g, obs[g]);
            end
        end
    endtask

    task automatic test_identity_edge();
        apply_reset();
        clear_stim();
        for (int i = 0; i < 64; i++) s_pix[i] = 8'(i);
        s_w[4] = 8'd255;
        for (int i = 9; i < 64; i++) s_w[i] = 8'h33;
        run_stream(66);
        checks++;
        if (obs[20] !== 8'd0)  begin failures++; $display("FAIL ident_before_first got %0d exp 0", obs[20]); end
        checks++;
        if (obs[21] !== 8'd8)  begin failures++; $display("FAIL ident_px18 got %0d exp 8", obs[21]); end
        checks++;
        if (obs[25] !== 8'd12) begin failures++; $display("FAIL ident_px22 got %0d exp 12", obs[25]); end
        checks++;
        if (obs[26] !== 8'd13) begin failures++; $display("FAIL ident_px23 got %0d exp 13", obs[26]); end
        checks++;
        if (obs[27] !== 8'd13) begin failures++; $display("FAIL edge_hold_px24 got %0d exp 13", obs[27]); end
        checks++;
        if (obs[28] !== 8'd13) begin failures++; $display("FAIL edge_hold_px25 got %0d exp 13", obs[28]); end
        checks++;
        if (obs[29] !== 8'd16) begin failures++; $display("FAIL ident_px26 got %0d exp 16", obs[29]); end
        for (int g = 0; g <= 66; g++) begin
            checks++;
            if (obs[g] !== expv[g]) begin
                failures++;
                $display("FAIL ident_stream cycle %0d got %0d exp %0d", g, obs[g], expv[g]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        clear_stim();
        for (int i = 0; i < 130; i++) s_pix[i] = 8'(i % 64);
        for (int i = 0; i < 64; i++) s_w[i] = 8'(i + 1);
        for (int i = 73; i < 128; i++) s_w[i] = 8'h77;
        s_w[68] = 8'd255;
        run_stream(130);
        checks++;
        if (obs[66] !== 8'd10) begin failures++; $display("FAIL b2b_last_f0 got %0d exp 10", obs[66]); end
        checks++;
        if (obs[84] !== 8'd10) begin failures++; $display("FAIL b2b_hold_across got %0d exp 10", obs[84]); end
        checks++;
        if (obs[85] !== 8'd8)  begin failures++; $display("FAIL b2b_first_f1 got %0d exp 8", obs[85]); end
        checks++;
        if (obs[130] !== 8'd53) begin failures++; $display("FAIL b2b_last_f1 got %0d exp 53", obs[130]); end
        for (int g = 0; g <= 130; g++) begin
            checks++;
            if (obs[g] !== expv[g]) begin
                failures++;
                $display("FAIL b2b_stream cycle %0d got %0d exp %0d", g, obs[g], expv[g]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        clear_stim();
        for (int i = 0; i < 64; i++) s_pix[i] = 8'(i);
        s_w[4] = 8'd255;
        run_stream(31);
        checks++;
        if (obs[31] !== 8'd18) begin failures++; $display("FAIL mid_before_reset got %0d exp 18", obs[31]); end
        reset = 1'b0;
        #1;
        checks++;
        if (dout !== 8'd0) begin failures++; $display("FAIL mid_reset_async got %0d exp 0", dout); end
        @(negedge clock);
        reset = 1'b1;
        clear_stim();
        for (int i = 0; i < 64; i++) begin
            s_pix[i] = 8'(i);
            s_w[i]   = 8'(i + 1);
        end
        run_stream(24);
        checks++;
        if (obs[20] !== 8'd0) begin failures++; $display("FAIL mid_restart_quiet got %0d exp 0", obs[20]); end
        checks++;
        if (obs[21] !== 8'd2) begin failures++; $display("FAIL mid_restart_px18 got %0d exp 2", obs[21]); end
        checks++;
        if (obs[22] !== 8'd2) begin failures++; $display("FAIL mid_restart_px19 got %0d exp 2", obs[22]); end
        for (int g = 0; g <= 24; g++) begin
            checks++;
            if (obs[g] !== expv[g]) begin
                failures++;
                $display("FAIL mid_restart_stream cycle %0d got %0d exp %0d", g, obs[g], expv[g]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        inpixel   = 8'd0;
        weight_in = 8'd0;
        @(negedge clock);
        test_reset();
        test_ramp();
        test_zero_weights();
        test_saturation();
        test_identity_edge();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
